serial_operand_feeder: RTL and testbench
========================================

// Module: serial_operand_feeder
// PURPOSE
//  Upstream stage of the serial adder. Accepts a parallel operand pair (a, b, cin) through a valid/ready handshake.
//  Pulses the adder's active-high reset for one cycle so its first-bit carry logic re-arms.
//  Then streams a/b LSB-first, one bit per clk, for WIDTH cycles; ser_cin is held for the whole transfer.
//  Downstream sum bits appear one clk after each operand bit (adder output is registered).
// PARAMETERS
//  WIDTH   8   operand width in bits; >=2
//  IDX_W   $clog2(WIDTH)   width of bit_idx (derived localparam, not overridable)
// PORTS
//  clk        in   1      rising-edge clock
//  reset_n    in   1      synchronous, active-low reset
//  in_valid   in   1      operand pair valid
//  in_ready   out  1      feeder can accept; =1 only in IDLE
//  in_a       in   WIDTH  operand A
//  in_b       in   WIDTH  operand B
//  in_cin     in   1      carry-in for bit 0
//  adder_rst  out  1      active-high reset pulse to serial adder
//  ser_a      out  1      current bit of A
//  ser_b      out  1      current bit of B
//  ser_cin    out  1      carry-in presented to adder; held for whole op
//  ser_valid  out  1      ser_a/ser_b carry a live bit this cycle
//  bit_idx    out  IDX_W  index of bit on ser_a/ser_b (0 = LSB)
//  last       out  1      =1 with ser_valid on bit WIDTH-1
// BEHAVIOUR
//  - All outputs are registered except in_ready, which decodes state==IDLE.
//  - Reset (reset_n=0 at a rising edge): state=IDLE; adder_rst=0; ser_a/ser_b/ser_cin/ser_valid/last=0; bit_idx=0; in_ready=1 next cycle.
//  - Reset mid-operation aborts immediately; the shift register and counter are discarded, and no partial completion is signalled.
//  - FSM IDLE -> CLEAR -> SHIFT -> IDLE:
//    IDLE: in_valid&in_ready at edge T0 -> latch in_a/in_b/in_cin into shift regs; go CLEAR.
//    CLEAR (cycle T0+1): adder_rst=1, ser_valid=0, ser_cin=latched cin; go SHIFT.
//    SHIFT (cycles T0+2 .. T0+1+WIDTH): adder_rst=0, ser_valid=1;
//      ser_a/ser_b = bit bit_idx of the latched operands; bit_idx counts 0..WIDTH-1;
//      shift regs move right by 1 per cycle; last=1 when bit_idx==WIDTH-1; then go IDLE.
//  - Throughput: one op per WIDTH+2 cycles. in_valid held high -> accepts at T0, T0+WIDTH+2, ...
//  - in_valid while busy: ignored and not acked; in_a/in_b may change freely after the accept edge.
//  - Outside SHIFT: ser_a=ser_b=0, last=0, bit_idx=0.
//  - ser_cin is stable from CLEAR through the last SHIFT cycle and returns to 0 in IDLE.
//  - bit_idx wraps only via return to IDLE; it never exceeds WIDTH-1.
// CONFIGURATION
//  SERIAL_FEEDER_SUB_EN defined:
//    - adds port in_sub (in, 1), latched at accept.
//    - When in_sub=1: ser_b streams ~in_b and ser_cin=1 regardless of in_cin, so the adder computes a-b.
//    - When in_sub=0: behaviour is identical to the non-SUB build.
//  SERIAL_FEEDER_SUB_EN undefined: port in_sub absent; ser_b = in_b bits; ser_cin = in_cin.
// TESTING  (WIDTH=8)
//  T1 a=0x5A b=0x3C cin=0, accept at T0 -> adder_rst=1 @T0+1.
//     ser_a LSB-first 0,1,0,1,1,0,1,0; ser_b 0,0,1,1,1,1,0,0; last @T0+9.
//     Collected adder sum = 0x96.
//  T2 a=0xFF b=0x01 cin=0 -> ser_a all 1s; ser_b 1,0,0,0,0,0,0,0.
//     Adder sum 0x00, final carry 1; in_ready=1 @T0+10.
//  T3 in_valid held 1 with 3 different pairs -> accepts exactly at T0, T0+10, T0+20; no bit gaps beyond CLEAR.
//  T4 reset_n=0 during SHIFT at bit_idx=3 -> next cycle all outputs 0, in_ready=1.
//     A new op after release streams from bit 0.
//  T5 [SUB_EN] a=0x10 b=0x01 in_sub=1 -> ser_b 0,1,1,1,1,1,1,1; ser_cin=1.
//     Adder sum 0x0F.
//  T6 [SUB_EN] in_sub=0, a=0x03 b=0x04 cin=1 -> ser_cin=1; ser_b 0,0,1,0,0,0,0,0; sum 0x08.

Source files
------------

// File: rtl/serial_operand_feeder_if.sv
// Bundle between the operand producer, the serial operand feeder and the serial adder.
// SERIAL_FEEDER_SUB_EN adds the in_sub request line.
interface serial_operand_feeder_if #(
    parameter int WIDTH = 8
);
    localparam int IDX_W = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
`ifdef SERIAL_FEEDER_SUB_EN
    logic             in_sub;
`endif
    logic             adder_rst;
    logic             ser_a;
    logic             ser_b;
    logic             ser_cin;
    logic             ser_valid;
    logic [IDX_W-1:0] bit_idx;
    logic             last;

    // master = operand producer / adder side, slave = the feeder itself
    modport master (
`ifdef SERIAL_FEEDER_SUB_EN
        output in_sub,
`endif
        output in_valid, in_a, in_b, in_cin,
        input  in_ready, adder_rst, ser_a, ser_b, ser_cin, ser_valid, bit_idx, last
    );

    modport slave (
`ifdef SERIAL_FEEDER_SUB_EN
        input  in_sub,
`endif
        input  in_valid, in_a, in_b, in_cin,
        output in_ready, adder_rst, ser_a, ser_b, ser_cin, ser_valid, bit_idx, last
    );
endinterface

// File: rtl/serial_operand_feeder.sv
// Accepts a parallel operand pair, pulses the serial adder's reset, then streams a/b LSB-first.
// Optional subtract mode is enabled with the SERIAL_FEEDER_SUB_EN macro.
module serial_operand_feeder #(
    parameter int WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    serial_operand_feeder_if.slave  bus
);
    localparam int IDX_W = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        SHIFT = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic             adder_rst_q, adder_rst_d;
    logic             ser_a_q, ser_a_d;
    logic             ser_b_q, ser_b_d;
    logic             ser_cin_q, ser_cin_d;
    logic             ser_valid_q, ser_valid_d;
    logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
    logic             last_q, last_d;

    logic             accept;
    logic [WIDTH-1:0] b_load;
    logic             cin_load;

    // Subtraction is a + ~b + 1, so only the loaded B word and carry-in change.
    always_comb begin
`ifdef SERIAL_FEEDER_SUB_EN
        b_load   = bus.in_sub ? ~bus.in_b : bus.in_b;
        cin_load = bus.in_sub | bus.in_cin;
`else
        b_load   = bus.in_b;
        cin_load = bus.in_cin;
`endif
    end

    assign accept       = bus.in_valid && (state_q == IDLE);
    assign bus.in_ready = (state_q == IDLE);

    always_comb begin
        state_d     = state_q;
        a_sr_d      = a_sr_q;
        b_sr_d      = b_sr_q;
        adder_rst_d = 1'b0;
        ser_a_d     = 1'b0;
        ser_b_d     = 1'b0;
        ser_cin_d   = ser_cin_q;
        ser_valid_d = 1'b0;
        bit_idx_d   = '0;
        last_d      = 1'b0;

        case (state_q)
            IDLE: begin
                ser_cin_d = 1'b0;
                if (accept) begin
                    a_sr_d      = bus.in_a;
                    b_sr_d      = b_load;
                    ser_cin_d   = cin_load;
                    adder_rst_d = 1'b1;
                    state_d     = CLEAR;
                end
            end
            CLEAR: begin
                ser_valid_d = 1'b1;
                ser_a_d     = a_sr_q[0];
                ser_b_d     = b_sr_q[0];
                a_sr_d      = a_sr_q >> 1;
                b_sr_d      = b_sr_q >> 1;
                state_d     = SHIFT;
            end
            SHIFT: begin
                // Registered outputs already show bit_idx_q; the final bit leaves with the return to IDLE.
                if (bit_idx_q == LAST_IDX) begin
                    ser_cin_d = 1'b0;
                    state_d   = IDLE;
                end else begin
                    ser_valid_d = 1'b1;
                    ser_a_d     = a_sr_q[0];
                    ser_b_d     = b_sr_q[0];
                    a_sr_d      = a_sr_q >> 1;
                    b_sr_d      = b_sr_q >> 1;
                    bit_idx_d   = bit_idx_q + 1'b1;
                    last_d      = ((bit_idx_q + 1'b1) == LAST_IDX);
                end
            end
            default: begin
                ser_cin_d = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            a_sr_q      <= '0;
            b_sr_q      <= '0;
            adder_rst_q <= 1'b0;
            ser_a_q     <= 1'b0;
            ser_b_q     <= 1'b0;
            ser_cin_q   <= 1'b0;
            ser_valid_q <= 1'b0;
            bit_idx_q   <= '0;
            last_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_sr_q      <= a_sr_d;
            b_sr_q      <= b_sr_d;
            adder_rst_q <= adder_rst_d;
            ser_a_q     <= ser_a_d;
            ser_b_q     <= ser_b_d;
            ser_cin_q   <= ser_cin_d;
            ser_valid_q <= ser_valid_d;
            bit_idx_q   <= bit_idx_d;
            last_q      <= last_d;
        end
    end

    assign bus.adder_rst = adder_rst_q;
    assign bus.ser_a     = ser_a_q;
    assign bus.ser_b     = ser_b_q;
    assign bus.ser_cin   = ser_cin_q;
    assign bus.ser_valid = ser_valid_q;
    assign bus.bit_idx   = bit_idx_q;
    assign bus.last      = last_q;
endmodule

// File: tb/tb_serial_operand_feeder.sv
// Self-checking bench for serial_operand_feeder: table vectors, random ops, throughput and reset corners.
// Streams are folded through a serial-adder model and compared with plain a+b+cin arithmetic.
module tb_serial_operand_feeder;
    localparam int W     = 8;
    localparam int IDX_W = $clog2(W);

    logic clk;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    serial_operand_feeder_if #(.WIDTH(W)) bus ();

    serial_operand_feeder #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W:0]   total;   // {carry_out, sum}
    } vec_t;

    vec_t vecs[$];

    // {in_ready, adder_rst, ser_valid, ser_cin, ser_a, ser_b, last, bit_idx}
    function automatic logic [6+IDX_W-1:0] obs();
        return {bus.in_ready, bus.adder_rst, bus.ser_valid, bus.ser_cin,
                bus.ser_a, bus.ser_b, bus.last, bus.bit_idx};
    endfunction

    function automatic logic [6+IDX_W-1:0] exp_obs(input logic rdy, rst, vld, cin,
                                                   input logic sa, sb, lst, input int idx);
        logic [IDX_W-1:0] i;
        i = IDX_W'(idx);
        return {rdy, rst, vld, cin, sa, sb, lst, i};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        bus.in_valid = 1'b0;
        bus.in_a     = W'($urandom);
        bus.in_b     = W'($urandom);
        bus.in_cin   = 1'($urandom);
`ifdef SERIAL_FEEDER_SUB_EN
        bus.in_sub   = 1'($urandom);
`endif
    endtask

    // One full operation: accept, CLEAR, W shift cycles, back to IDLE.
    task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic sub, input logic [W:0] total);
        logic [W-1:0] eb;
        logic         ecin;
        logic         carry;
        logic [W-1:0] sum;
        int           budget;
        eb   = sub ? ~b : b;
        ecin = sub ? 1'b1 : cin;
        sum  = '0;
        budget = 0;
        @(negedge clk);
        while (!bus.in_ready && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        chk({name, " ready_before_accept"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_cin   = cin;
`ifdef SERIAL_FEEDER_SUB_EN
        bus.in_sub   = sub;
`endif
        @(posedge clk);
        #1 drive_idle();
        @(negedge clk);
        chk({name, " clear"}, 32'(obs()), 32'(exp_obs(1'b0, 1'b1, 1'b0, ecin, 1'b0, 1'b0, 1'b0, 0)));
        carry = bus.ser_cin;
        for (int k = 0; k < W; k++) begin
            @(negedge clk);
            chk($sformatf("%s bit%0d", name, k), 32'(obs()),
                32'(exp_obs(1'b0, 1'b0, 1'b1, ecin, a[k], eb[k], (k == W-1), k)));
            if (bus.ser_valid) begin
                sum[k] = bus.ser_a ^ bus.ser_b ^ carry;
                carry  = (bus.ser_a & bus.ser_b) | (carry & (bus.ser_a ^ bus.ser_b));
            end
        end
        @(negedge clk);
        chk({name, " idle_after"}, 32'(obs()), 32'(exp_obs(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0)));
        chk({name, " adder_sum"}, 32'({carry, sum}), 32'(total));
        $display("op %s a=%h b=%h cin=%0d sub=%0d -> sum=%h cout=%0d", name, a, b, cin, sub, sum, carry);
    endtask

    // in_valid held high across three pairs; accepts must land exactly W+2 apart.
    task automatic throughput_test();
        logic [W-1:0] pa[3];
        logic [W-1:0] pb[3];
        logic [W-1:0] ra[3];
        logic [W-1:0] rb[3];
        int           acc[3];
        int           first_bit[3];
        int           nacc, sb, op, bt;
        nacc = 0;
        sb   = 0;
        for (int i = 0; i < 3; i++) begin
            pa[i] = W'($urandom);
            pb[i] = W'($urandom);
            ra[i] = '0;
            rb[i] = '0;
            acc[i] = -1;
            first_bit[i] = -1;
        end
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_a     = pa[0];
        bus.in_b     = pb[0];
        bus.in_cin   = 1'b0;
`ifdef SERIAL_FEEDER_SUB_EN
        bus.in_sub   = 1'b0;
`endif
        for (int cyc = 0; cyc < 45; cyc++) begin
            logic took;
            took = 1'b0;
            if (bus.ser_valid && sb < 3*W) begin
                op = sb / W;
                bt = sb % W;
                ra[op][bt] = bus.ser_a;
                rb[op][bt] = bus.ser_b;
                if (bt == 0) first_bit[op] = cyc;
                sb++;
            end
            if (bus.in_ready && bus.in_valid && nacc < 3) begin
                acc[nacc] = cyc;
                nacc++;
                took = 1'b1;
            end
            @(posedge clk);
            #1;
            if (took) begin
                if (nacc < 3) begin
                    bus.in_a = pa[nacc];
                    bus.in_b = pb[nacc];
                end else begin
                    drive_idle();
                end
            end
            @(negedge clk);
        end
        drive_idle();
        chk("t3 accept_count", 32'(nacc), 32'd3);
        chk("t3 stream_bits", 32'(sb), 32'(3*W));
        for (int i = 0; i < 3; i++) begin
            if (i > 0) chk($sformatf("t3 accept_gap%0d", i), 32'(acc[i] - acc[i-1]), 32'(W + 2));
            chk($sformatf("t3 first_bit%0d", i), 32'(first_bit[i]), 32'(acc[i] + 2));
            chk($sformatf("t3 op%0d_a", i), 32'(ra[i]), 32'(pa[i]));
            chk($sformatf("t3 op%0d_b", i), 32'(rb[i]), 32'(pb[i]));
        end
        $display("t3 accepts at %0d %0d %0d, %0d bits streamed", acc[0], acc[1], acc[2], sb);
    endtask

    task automatic reset_mid_op_test();
        int budget;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_a     = 8'hA5;
        bus.in_b     = 8'h3C;
        bus.in_cin   = 1'b1;
`ifdef SERIAL_FEEDER_SUB_EN
        bus.in_sub   = 1'b0;
`endif
        @(posedge clk);
        #1 drive_idle();
        budget = 0;
        @(negedge clk);
        while (!(bus.ser_valid && bus.bit_idx == IDX_W'(3)) && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        chk("t4 reached_bit3", 32'(bus.bit_idx), 32'd3);
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("t4 after_reset", 32'(obs()), 32'(exp_obs(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0)));
        reset_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("t4 idle_after_release", 32'(obs()), 32'(exp_obs(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0)));
        $display("t4 reset during bit 3 handled");
    endtask

    initial begin
        reset_n = 1'b0;
        drive_idle();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_state", 32'(obs()), 32'(exp_obs(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0)));
        reset_n = 1'b1;

        vecs.push_back('{a: 8'h5A, b: 8'h3C, cin: 1'b0, sub: 1'b0, total: 9'h096});
        vecs.push_back('{a: 8'hFF, b: 8'h01, cin: 1'b0, sub: 1'b0, total: 9'h100});
        vecs.push_back('{a: 8'h00, b: 8'h00, cin: 1'b1, sub: 1'b0, total: 9'h001});
        vecs.push_back('{a: 8'h80, b: 8'h80, cin: 1'b1, sub: 1'b0, total: 9'h101});
`ifdef SERIAL_FEEDER_SUB_EN
        vecs.push_back('{a: 8'h10, b: 8'h01, cin: 1'b0, sub: 1'b1, total: 9'h10F});
        vecs.push_back('{a: 8'h03, b: 8'h04, cin: 1'b1, sub: 1'b0, total: 9'h008});
`endif
        foreach (vecs[i])
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, vecs[i].total);

        throughput_test();
        reset_mid_op_test();
        run_op("post_reset", 8'h0F, 8'hF0, 1'b0, 1'b0, 9'h0FF);

        for (int r = 0; r < 20; r++) begin
            logic [W-1:0] a, b;
            logic         cin, sub;
            logic [W:0]   total;
            a   = W'($urandom);
            b   = W'($urandom);
            cin = 1'($urandom);
`ifdef SERIAL_FEEDER_SUB_EN
            sub = 1'($urandom);
`else
            sub = 1'b0;
`endif
            if (sub) total = (W+1)'(a) + (W+1)'(~b) + (W+1)'(1);
            else     total = (W+1)'(a) + (W+1)'(b) + (W+1)'(cin);
            run_op($sformatf("rnd%0d", r), a, b, cin, sub, total);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end
endmodule
